led_blink_multi: RTL

Multi-channel LED driver and the parametrised successor of the single-LED fixed-rate blinker. A shared prescaler generates a slow tick. Each of NUM_CH channels runs its own tick counter in one of four modes: OFF, ON, BLINK or PWM. Channels are configured at run time through a valid/ready write port. The block sits between board-level LED pins and any controller logic (FSM, UART command decoder) that sets LED patterns.

---
 rtl/led_blink_multi_if.sv | 31 +++
 rtl/led_blink_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_multi_if
//  Brief    : Configuration write port (valid/ready) for led_blink_multi.
//  Revision : 1.0 - initial release
// ============================================================================
interface led_blink_multi_if #(
    parameter int NUM_CH = 4,
    parameter int PER_W  = 16
);
    localparam int CH_W = $clog2(NUM_CH) + 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PER_W-1:0] cfg_period;
    logic [PER_W-1:0] cfg_duty;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_duty,
        output cfg_ready, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/led_blink_multi.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_multi
//  Brief    : Multi-channel LED driver (OFF/ON/BLINK/PWM) on a shared tick.
//             Optional macro LED_BCAST_EN: out-of-range channel = broadcast.
//  Revision : 1.0 - initial release
// ============================================================================
module led_blink_multi #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int NUM_CH     = 4,
    parameter int PER_W      = 16,
    parameter int DEF_PERIOD = 500
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    led_blink_multi_if.slave       cfg,
    output logic                   tick,
    output logic [NUM_CH-1:0]      led
);

    localparam int c_TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int c_PRE_W    = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(c_TICK_DIV - 1);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;
    localparam logic [1:0] c_MODE_PWM   = 2'b11;

    // ------------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic               r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pre == c_PRE_MAX);
            if (r_pre == c_PRE_MAX) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign tick = r_tick;

    // ------------------------------------------------------------------------
    // Write handshake: one busy cycle after every accepted write
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_READY: begin
                w_ready = 1'b1;
                if (cfg.cfg_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    assign cfg.cfg_ready = w_ready;

    // ------------------------------------------------------------------------
    // Channel decode
    // ------------------------------------------------------------------------
    logic [31:0] w_ch_idx;
    logic        w_oob;

    assign w_ch_idx = 32'(cfg.cfg_ch);
    assign w_oob    = (w_ch_idx >= 32'(NUM_CH));

`ifdef LED_BCAST_EN
    assign cfg.cfg_err = 1'b0;
`else
    logic r_err;

    // Rejected writes still complete the handshake; only the error flag reacts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_oob;
        end
    end

    assign cfg.cfg_err = r_err;
`endif

    // ------------------------------------------------------------------------
    // Per-channel counter, phase and LED output
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             w_load;
        logic [PER_W-1:0] w_eff;
        logic             w_wrap;
        logic [1:0]       r_mode;
        logic [PER_W-1:0] r_period;
        logic [PER_W-1:0] r_duty;
        logic [PER_W-1:0] r_cnt;
        logic             r_phase;
        logic             r_led;

`ifdef LED_BCAST_EN
        assign w_load = w_accept && ((w_ch_idx == 32'(c)) || w_oob);
`else
        assign w_load = w_accept && (w_ch_idx == 32'(c));
`endif
        assign w_eff  = (r_period == '0) ? PER_W'(1) : r_period;
        assign w_wrap = (r_cnt >= (w_eff - PER_W'(1)));

        // A write on a tick edge restarts the channel and drops that tick.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode   <= c_MODE_OFF;
                r_period <= PER_W'(DEF_PERIOD);
                r_duty   <= '0;
                r_cnt    <= '0;
                r_phase  <= 1'b0;
            end else if (w_load) begin
                r_mode   <= cfg.cfg_mode;
                r_period <= cfg.cfg_period;
                r_duty   <= cfg.cfg_duty;
                r_cnt    <= '0;
                r_phase  <= 1'b0;
            end else if (r_tick) begin
                if (w_wrap) begin
                    r_cnt <= '0;
                    if (r_mode == c_MODE_BLINK) begin
                        r_phase <= ~r_phase;
                    end
                end else begin
                    r_cnt <= r_cnt + PER_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_led <= 1'b0;
            end else begin
                case (r_mode)
                    c_MODE_OFF:   r_led <= 1'b0;
                    c_MODE_ON:    r_led <= 1'b1;
                    c_MODE_BLINK: r_led <= r_phase;
                    c_MODE_PWM:   r_led <= (r_cnt < r_duty);
                    default:      r_led <= 1'b0;
                endcase
            end
        end

        assign led[c] = r_led;
    end

endmodule
`default_nettype wire
